// File: rtl/completion_ring_writer.sv
`default_nettype none
// ============================================================================
// completion_ring_writer: packs per-kernel completion tags into lines, AXI-writes them to a host ring
// Option CMPL_TIMEOUT_FLUSH_EN: idle-timeout flush of partial lines.  Rev 1.0
// ============================================================================
module completion_ring_writer #(
  parameter int KERNEL_NUM     = 8,
  parameter int DATA_WIDTH     = 512,
  parameter int ADDR_WIDTH     = 64,
  parameter int ID_WIDTH       = 1,
  parameter int AWUSER_WIDTH   = 8,
  parameter int FIFO_DEPTH     = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [KERNEL_NUM-1:0]     kernel_start,
  input  logic [KERNEL_NUM-1:0]     kernel_complete,
  input  logic [23:0]               start_tag,
  input  logic [ADDR_WIDTH-1:0]     completion_addr,
  input  logic [31:0]               completion_size,
  input  logic                      real_done,
  output logic                      flush_done,
  output logic                      overflow,
  output logic                      bus_error,
  output logic [ID_WIDTH-1:0]       m_axi_awid,
  output logic [ADDR_WIDTH-1:0]     m_axi_awaddr,
  output logic [7:0]                m_axi_awlen,
  output logic [2:0]                m_axi_awsize,
  output logic [1:0]                m_axi_awburst,
  output logic [3:0]                m_axi_awcache,
  output logic                      m_axi_awlock,
  output logic [2:0]                m_axi_awprot,
  output logic [3:0]                m_axi_awqos,
  output logic [3:0]                m_axi_awregion,
  output logic [AWUSER_WIDTH-1:0]   m_axi_awuser,
  output logic                      m_axi_awvalid,
  input  logic                      m_axi_awready,
  output logic [ID_WIDTH-1:0]       m_axi_wid,
  output logic [DATA_WIDTH-1:0]     m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0]   m_axi_wstrb,
  output logic                      m_axi_wlast,
  output logic                      m_axi_wvalid,
  input  logic                      m_axi_wready,
  output logic                      m_axi_bready,
  input  logic [ID_WIDTH-1:0]       m_axi_bid,
  input  logic [1:0]                m_axi_bresp,
  input  logic                      m_axi_bvalid
);

  localparam int          EPL        = DATA_WIDTH / 32;
  localparam int          LINE_BYTES = DATA_WIDTH / 8;
  localparam int          KW         = (KERNEL_NUM > 1) ? $clog2(KERNEL_NUM) : 1;
  localparam int          EW         = $clog2(EPL);
  localparam int          FW         = $clog2(FIFO_DEPTH);
  localparam logic [31:0] LINE_INC   = 32'(LINE_BYTES);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_RESP  = 2'd2,
    ST_ADV   = 2'd3
  } state_t;

  state_t                  state, state_nxt;
  logic                    awvalid_nxt, wvalid_nxt, berr_set;

  logic [23:0]             tag [KERNEL_NUM];
  logic [KERNEL_NUM-1:0]   pending;
  logic [KERNEL_NUM-1:0]   grant_oh;
  logic [KW-1:0]           rr_ptr, grant_idx, scan_idx;
  logic                    grant_vld;
  int                      scan;

  logic [31:0]             fifo_mem [FIFO_DEPTH];
  logic [FW:0]             wr_ptr, rd_ptr;
  logic                    fifo_full, fifo_empty;
  logic [31:0]             fifo_dout;

  logic [DATA_WIDTH-1:0]   line_buf [2];
  logic [1:0]              line_rdy;
  logic                    fill_sel, wr_sel;
  logic [EW-1:0]           fill_cnt;
  logic [31:0]             offset;
  logic                    pop;

  logic                    real_done_q, flush_armed, flush_busy;
  logic                    flush_go, flush_mark, flush_empty;
  logic                    tmo_mark, part_mark;

  // ---------------------------------------------------------------- tags
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < KERNEL_NUM; i++) tag[i] <= '0;
    end else begin
      for (int i = 0; i < KERNEL_NUM; i++)
        if (kernel_start[i]) tag[i] <= start_tag;
    end
  end

  // ------------------------------------------------- round-robin arbiter
  // Scan from the farthest offset down so the nearest pending bit to rr_ptr wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    grant_oh  = '0;
    scan      = 0;
    scan_idx  = '0;
    if (!fifo_full) begin
      for (int off = KERNEL_NUM - 1; off >= 0; off--) begin
        scan = int'(rr_ptr) + off;
        if (scan >= KERNEL_NUM) scan = scan - KERNEL_NUM;
        scan_idx = KW'(scan);
        if (pending[scan_idx]) begin
          grant_vld = 1'b1;
          grant_idx = scan_idx;
        end
      end
    end
    if (grant_vld) grant_oh[grant_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending  <= '0;
      overflow <= 1'b0;
      rr_ptr   <= '0;
    end else begin
      pending <= (pending & ~grant_oh) | kernel_complete;
      if (|(pending & kernel_complete)) overflow <= 1'b1;
      if (grant_vld)
        rr_ptr <= (grant_idx == KW'(KERNEL_NUM - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  // ---------------------------------------------------------- entry FIFO
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[FW] != rd_ptr[FW]) && (wr_ptr[FW-1:0] == rd_ptr[FW-1:0]);
  assign fifo_dout  = fifo_mem[rd_ptr[FW-1:0]];

  always_ff @(posedge clk) begin
    if (grant_vld) fifo_mem[wr_ptr[FW-1:0]] <= {tag[grant_idx], 8'h01};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (grant_vld) wr_ptr <= wr_ptr + 1'b1;
      if (pop)       rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // ------------------------------------------------- packer / flush control
  // Popping is held off during a final flush so the ping-pong reset cannot drop entries.
  assign pop         = !fifo_empty && !line_rdy[fill_sel] && !flush_busy;
  assign flush_go    = flush_armed && !flush_busy && (pending == '0) && fifo_empty &&
                       (line_rdy == 2'b00);
  assign flush_mark  = flush_go && (fill_cnt != '0);
  assign flush_empty = flush_go && (fill_cnt == '0);
  assign part_mark   = flush_mark || tmo_mark;

`ifdef CMPL_TIMEOUT_FLUSH_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt;
  logic          tmo_idle;

  assign tmo_idle = (state == ST_IDLE) && (fill_cnt != '0) && !pop &&
                    !line_rdy[fill_sel] && !flush_busy;
  assign tmo_mark = tmo_idle && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst || !tmo_idle || tmo_mark) tmo_cnt <= '0;
    else                              tmo_cnt <= tmo_cnt + 1'b1;
  end
`else
  logic unused_tmo;
  assign tmo_mark   = 1'b0;
  assign unused_tmo = &{1'b0, 32'(TIMEOUT_CYCLES)};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      line_buf[0] <= '0;
      line_buf[1] <= '0;
      line_rdy    <= '0;
      fill_sel    <= 1'b0;
      wr_sel      <= 1'b0;
      fill_cnt    <= '0;
      offset      <= '0;
      real_done_q <= 1'b0;
      flush_armed <= 1'b0;
      flush_busy  <= 1'b0;
      flush_done  <= 1'b0;
    end else begin
      real_done_q <= real_done;
      flush_done  <= 1'b0;

      if (pop) begin
        line_buf[fill_sel][{fill_cnt, 5'b0} +: 32] <= fifo_dout;
        fill_cnt <= fill_cnt + 1'b1;
        if (fill_cnt == EW'(EPL - 1)) begin
          line_rdy[fill_sel] <= 1'b1;
          fill_sel           <= ~fill_sel;
        end
      end

      if (part_mark) begin
        line_rdy[fill_sel] <= 1'b1;
        fill_sel           <= ~fill_sel;
        fill_cnt           <= '0;
      end

      if (flush_go)   flush_armed <= 1'b0;
      if (real_done && !real_done_q) flush_armed <= 1'b1;
      if (flush_mark) flush_busy  <= 1'b1;

      if (flush_empty) begin
        flush_done <= 1'b1;
        offset     <= '0;
        fill_sel   <= 1'b0;
        wr_sel     <= 1'b0;
      end

      if (state == ST_ADV) begin
        line_rdy[wr_sel] <= 1'b0;
        line_buf[wr_sel] <= '0;
        wr_sel           <= ~wr_sel;
        offset           <= (offset + LINE_INC == completion_size) ? '0 : offset + LINE_INC;
        if (flush_busy) begin
          flush_busy <= 1'b0;
          flush_done <= 1'b1;
          offset     <= '0;
          fill_sel   <= 1'b0;
          wr_sel     <= 1'b0;
          fill_cnt   <= '0;
        end
      end
    end
  end

  // ------------------------------------------------------------ writer FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      m_axi_awvalid <= 1'b0;
      m_axi_wvalid  <= 1'b0;
      bus_error     <= 1'b0;
    end else begin
      state         <= state_nxt;
      m_axi_awvalid <= awvalid_nxt;
      m_axi_wvalid  <= wvalid_nxt;
      if (berr_set) bus_error <= 1'b1;
    end
  end

  always_comb begin
    state_nxt   = state;
    awvalid_nxt = m_axi_awvalid;
    wvalid_nxt  = m_axi_wvalid;
    berr_set    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (line_rdy[wr_sel]) begin
          state_nxt   = ST_WRITE;
          awvalid_nxt = 1'b1;
          wvalid_nxt  = 1'b1;
        end
      end
      ST_WRITE: begin
        if (m_axi_awready) awvalid_nxt = 1'b0;
        if (m_axi_wready)  wvalid_nxt  = 1'b0;
        if (!awvalid_nxt && !wvalid_nxt) state_nxt = ST_RESP;
      end
      ST_RESP: begin
        if (m_axi_bvalid) begin
          if (m_axi_bresp == 2'b00) begin
            state_nxt = ST_ADV;
          end else begin
            state_nxt   = ST_WRITE;
            awvalid_nxt = 1'b1;
            wvalid_nxt  = 1'b1;
            berr_set    = 1'b1;
          end
        end
      end
      ST_ADV:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // ------------------------------------------------------------- AXI ties
  logic unused_axi;
  assign unused_axi     = &{1'b0, m_axi_bid};

  assign m_axi_awid     = '0;
  assign m_axi_awaddr   = completion_addr + ADDR_WIDTH'(offset);
  assign m_axi_awlen    = 8'd0;
  assign m_axi_awsize   = 3'($clog2(LINE_BYTES));
  assign m_axi_awburst  = 2'b01;
  assign m_axi_awcache  = 4'b0011;
  assign m_axi_awlock   = 1'b0;
  assign m_axi_awprot   = 3'b000;
  assign m_axi_awqos    = 4'b0000;
  assign m_axi_awregion = 4'b0000;
  assign m_axi_awuser   = '0;
  assign m_axi_wid      = '0;
  assign m_axi_wdata    = line_buf[wr_sel];
  assign m_axi_wstrb    = '1;
  assign m_axi_wlast    = m_axi_wvalid;
  assign m_axi_bready   = 1'b1;

endmodule
`default_nettype wire

// File: tb/tb_completion_ring_writer.sv
`default_nettype none
// ============================================================================
// tb_completion_ring_writer: directed scoreboard bench for completion_ring_writer
// Rev 1.0
// ============================================================================
module tb_completion_ring_writer;

  localparam logic [63:0] BASE = 64'h0000_0000_1000_0000;
  localparam logic [31:0] SIZE = 32'd128;

  logic         clk;
  logic         rst;
  logic [7:0]   kernel_start, kernel_complete;
  logic [23:0]  start_tag;
  logic [63:0]  completion_addr;
  logic [31:0]  completion_size;
  logic         real_done;
  logic         flush_done, overflow, bus_error;
  logic [0:0]   awid, wid, bid;
  logic [63:0]  awaddr;
  logic [7:0]   awlen, awuser;
  logic [2:0]   awsize, awprot;
  logic [1:0]   awburst, bresp;
  logic [3:0]   awcache, awqos, awregion;
  logic         awlock, awvalid, awready;
  logic [511:0] wdata;
  logic [63:0]  wstrb;
  logic         wlast, wvalid, wready, bready, bvalid;

  completion_ring_writer #(.TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .rst(rst),
    .kernel_start(kernel_start), .kernel_complete(kernel_complete),
    .start_tag(start_tag), .completion_addr(completion_addr),
    .completion_size(completion_size), .real_done(real_done),
    .flush_done(flush_done), .overflow(overflow), .bus_error(bus_error),
    .m_axi_awid(awid), .m_axi_awaddr(awaddr), .m_axi_awlen(awlen),
    .m_axi_awsize(awsize), .m_axi_awburst(awburst), .m_axi_awcache(awcache),
    .m_axi_awlock(awlock), .m_axi_awprot(awprot), .m_axi_awqos(awqos),
    .m_axi_awregion(awregion), .m_axi_awuser(awuser), .m_axi_awvalid(awvalid),
    .m_axi_awready(awready), .m_axi_wid(wid), .m_axi_wdata(wdata),
    .m_axi_wstrb(wstrb), .m_axi_wlast(wlast), .m_axi_wvalid(wvalid),
    .m_axi_wready(wready), .m_axi_bready(bready), .m_axi_bid(bid),
    .m_axi_bresp(bresp), .m_axi_bvalid(bvalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0]  addr;
    logic [511:0] data;
  } exp_t;

  exp_t         exp_q[$];
  logic [1:0]   resp_q[$];
  int           tests = 0;
  int           fails = 0;
  int           wr_cnt = 0;
  int           exp_total = 0;

  // Reference model state: tags, arbitration pointer, line under construction, ring offset
  logic [23:0]  tag_m [8];
  int           ptr_m = 0;
  logic [511:0] cur_line = '0;
  int           cur_n = 0;
  logic [31:0]  off_m = '0;
  bit           dup_first = 0;

  task automatic check(input string name, input logic [511:0] got, input logic [511:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic emit_line();
    exp_t e;
    e.addr = BASE + 64'(off_m);
    e.data = cur_line;
    exp_q.push_back(e);
    exp_total++;
    if (dup_first) begin
      exp_q.push_back(e);
      exp_total++;
      dup_first = 0;
    end
    off_m    = (off_m + 32'd64 == SIZE) ? 32'd0 : off_m + 32'd64;
    cur_line = '0;
    cur_n    = 0;
  endtask

  task automatic add_entry(input int k);
    cur_line[cur_n*32 +: 32] = {tag_m[k], 8'h01};
    cur_n++;
    if (cur_n == 16) emit_line();
  endtask

  task automatic single(input int k);
    add_entry(k);
    ptr_m = (k + 1) % 8;
    kernel_complete = 8'(1 << k);
    @(negedge clk);
    kernel_complete = '0;
    repeat (3) @(negedge clk);
  endtask

  task automatic burst();
    for (int i = 0; i < 8; i++) add_entry((ptr_m + i) % 8);
    kernel_complete = 8'hFF;
    @(negedge clk);
    kernel_complete = '0;
    repeat (12) @(negedge clk);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("drain_queue_empty", 512'(exp_q.size()), 512'(0));
    repeat (6) @(negedge clk);
  endtask

  // AXI slave and scoreboard consumer; all activity on the falling edge
  initial begin : axi_slave
    logic [63:0]  cap_addr;
    logic [511:0] cap_data;
    bit got_aw, got_w, b_due;
    exp_t e;
    awready = 0; wready = 0; bvalid = 0; bresp = 2'b00; bid = '0;
    got_aw = 0; got_w = 0; b_due = 0;
    cap_addr = '0; cap_data = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        got_aw = 0; got_w = 0; b_due = 0; bvalid = 0; awready = 0; wready = 0;
        continue;
      end
      if (bvalid && bready) bvalid = 0;
      if (b_due) begin
        bvalid = 1;
        bresp  = (resp_q.size() != 0) ? resp_q.pop_front() : 2'b00;
        b_due  = 0;
      end
      awready = ($urandom_range(0, 3) != 0);
      wready  = ($urandom_range(0, 3) != 0);
      if (awvalid && awready && !got_aw) begin
        got_aw = 1;
        cap_addr = awaddr;
        check("aw_attr", 512'({awlen, awsize, awburst, awcache}), 512'({8'd0, 3'd6, 2'b01, 4'b0011}));
      end
      if (wvalid && wready && !got_w) begin
        got_w = 1;
        cap_data = wdata;
        check("w_attr", 512'({wlast, &wstrb}), 512'(2'b11));
      end
      if (got_aw && got_w) begin
        got_aw = 0; got_w = 0; b_due = 1;
        wr_cnt++;
        tests++;
        assert (exp_q.size() != 0) else begin
          fails++;
          $error("FAIL unexpected_write: got addr %0h expected no write", cap_addr);
        end
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("awaddr", 512'(cap_addr), 512'(e.addr));
          check("wdata", cap_data, e.data);
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int  wc, n, extra;
    bit  seen;
    rst = 1; kernel_start = '0; kernel_complete = '0; start_tag = '0; real_done = 0;
    completion_addr = BASE; completion_size = SIZE;
    repeat (3) @(negedge clk);
    check("reset_awvalid", 512'(awvalid), 512'(0));
    check("reset_wvalid", 512'(wvalid), 512'(0));
    check("reset_flags", 512'({flush_done, overflow, bus_error}), 512'(0));
    rst = 0;
    @(negedge clk);

    for (int k = 0; k < 8; k++) begin
      tag_m[k]     = (k == 3) ? 24'hABCDEF : 24'(32'h010203 * (k + 1));
      kernel_start = 8'(1 << k);
      start_tag    = tag_m[k];
      @(negedge clk);
    end
    kernel_start = '0;

    // First line: kernel 3 first, then 15 more; its first B is SLVERR
    resp_q.push_back(2'b10);
    dup_first = 1;
    check("bus_error_before", 512'(bus_error), 512'(0));
    single(3);
    for (int i = 0; i < 15; i++) single(i % 8);
    drain();
    check("bus_error_sticky", 512'(bus_error), 512'(1));

    // Bursts from pointer 0 and pointer 5
    single(7);
    burst();
    single(4);
    burst();
    burst();
    drain();

    // Back-to-back completion on kernel 2 raises overflow and yields two entries
    check("overflow_before", 512'(overflow), 512'(0));
    single(1);
    add_entry(2); add_entry(2); ptr_m = 3;
    kernel_complete = 8'h04; @(negedge clk);
    kernel_complete = 8'h04; @(negedge clk);
    kernel_complete = '0; repeat (3) @(negedge clk);
    single(6); single(0); single(5);
    drain();
    check("overflow_sticky", 512'(overflow), 512'(1));

    // Retag kernel 1, then leave five entries in a partial line
    kernel_start = 8'h02; start_tag = 24'h5A5A5A; tag_m[1] = 24'h5A5A5A;
    @(negedge clk);
    kernel_start = '0;
    single(1); single(7); single(3); single(1); single(4);

    wc = wr_cnt;
`ifdef CMPL_TIMEOUT_FLUSH_EN
    emit_line();
    repeat (90) @(negedge clk);
    drain();
    check("timeout_write", 512'(wr_cnt), 512'(wc + 1));
`else
    repeat (90) @(negedge clk);
    check("no_partial_write", 512'(wr_cnt), 512'(wc));
`endif

    // Final flush
    if (cur_n != 0) emit_line();
    off_m = '0;
    real_done = 1;
    seen = 0;
    n = 0;
    while (!seen && n < 400) begin
      @(negedge clk);
      n++;
      if (flush_done) seen = 1;
    end
    check("flush_done_seen", 512'(seen), 512'(1));
    check("flush_line_written", 512'(exp_q.size()), 512'(0));
    @(negedge clk);
    check("flush_done_pulse", 512'(flush_done), 512'(0));
    extra = 0;
    repeat (20) begin
      @(negedge clk);
      if (flush_done) extra++;
    end
    check("flush_done_once", 512'(extra), 512'(0));
    real_done = 0;
    @(negedge clk);

    // Ring restarts at base after the flush
    burst();
    burst();
    drain();
    check("write_count", 512'(wr_cnt), 512'(exp_total));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
